// File: rtl/alu_mdu_seq.sv
// Handshaked EX-stage execute unit: single-cycle RV32I ALU ops plus iterative
// shift-add multiply and restoring divide for the M extension.
module alu_mdu_seq #(
    parameter int XLEN   = 32,
    parameter bit MDU_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int SHAMT_W = $clog2(XLEN);
    localparam int CNT_W   = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t              state_q, state_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                neg_q, neg_d;
    logic                hi_q, hi_d;

    logic                accept, is_m, is_div, div_special;
    logic                a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0]     a_mag, b_mag, alu_res, special_res, fast_res;
    logic [SHAMT_W-1:0]  shamt;
    logic [XLEN:0]       mul_sum, rem_sh, diff;
    logic [2*XLEN-1:0]   mul_next, div_next, prod_fix;
    logic [XLEN-1:0]     mul_res, div_val, div_res;

    assign in_ready  = ((state_q == IDLE) | ((state_q == DONE) & out_ready)) & ~flush;
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == MUL) | (state_q == DIV);
    assign result    = result_q;

    assign is_m   = (op[4:3] == 2'b10);
    assign is_div = op[2];
    assign shamt  = src2[SHAMT_W-1:0];

    always_comb begin
        alu_res = '0;
        case (op)
            5'h00, 5'h02: alu_res = src1 + src2;
            5'h01:        alu_res = src2;
            5'h03:        alu_res = (src1 + src2) & ~{{(XLEN-1){1'b0}}, 1'b1};
            5'h04:        alu_res = {{(XLEN-1){1'b0}}, $signed(src1) < $signed(src2)};
            5'h05:        alu_res = src1 ^ src2;
            5'h06:        alu_res = src1 | src2;
            5'h07:        alu_res = src1 & src2;
            5'h08:        alu_res = src1 << shamt;
            5'h09:        alu_res = $signed(src1) >>> shamt;
            5'h0A:        alu_res = src1 >> shamt;
            5'h0B:        alu_res = src1 - src2;
            5'h0C:        alu_res = {{(XLEN-1){1'b0}}, src1 < src2};
            default:      alu_res = '0;
        endcase
    end

    // Signedness per M op; magnitudes feed the unsigned iterative datapath
    assign a_sgn = is_div ? ~op[0] : (op[1:0] == 2'b01) | (op[1:0] == 2'b10);
    assign b_sgn = is_div ? ~op[0] : (op[1:0] == 2'b01);
    assign a_neg = a_sgn & src1[XLEN-1];
    assign b_neg = b_sgn & src2[XLEN-1];
    assign a_mag = a_neg ? -src1 : src1;
    assign b_mag = b_neg ? -src2 : src2;

    always_comb begin
        div_special = 1'b0;
        special_res = '0;
        if (is_div && src2 == '0) begin
            div_special = 1'b1;
            special_res = op[1] ? src1 : '1;
        end else if (is_div && !op[0] && src1 == {1'b1, {(XLEN-1){1'b0}}} && src2 == '1) begin
            div_special = 1'b1;
            special_res = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    assign fast_res = is_m ? (MDU_EN ? special_res : '0) : alu_res;

    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
    assign prod_fix = neg_q ? -mul_next : mul_next;
    assign mul_res  = hi_q ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];

    // Remainder lives in the upper half, dividend/quotient shifts through the lower half
    assign rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign diff     = rem_sh - {1'b0, opnd_q};
    assign div_next = {(diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0]), acc_q[XLEN-2:0], ~diff[XLEN]};
    assign div_val  = hi_q ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];
    assign div_res  = neg_q ? -div_val : div_val;

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE && out_ready) state_d = IDLE;
                if (accept) begin
                    if (is_m && MDU_EN && !div_special) begin
                        state_d = is_div ? DIV : MUL;
                        cnt_d   = CNT_W'(XLEN);
                        acc_d   = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
                        opnd_d  = is_div ? b_mag : a_mag;
                        neg_d   = (is_div && op[1]) ? a_neg : (a_neg ^ b_neg);
                        hi_d    = is_div ? op[1] : (op[1:0] != 2'b00);
                    end else begin
                        state_d  = DONE;
                        result_d = fast_res;
                    end
                end
            end
            MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == 1) begin
                    state_d  = DONE;
                    result_d = mul_res;
                end
            end
            DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == 1) begin
                    state_d  = DONE;
                    result_d = div_res;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d  = IDLE;
            result_d = result_q;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            hi_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
        end
    end
endmodule

// File: tb/tb_alu_mdu_seq.sv
// Scoreboard bench for alu_mdu_seq: a behavioural model pushes expected results
// and latencies at issue; they are popped and compared when out_valid appears.
module tb_alu_mdu_seq;
    logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [4:0]  op;
    logic [31:0] src1, src2, result;
    int          cyc, total, bad;
    logic [31:0] lastExp;

    typedef struct {
        string       tag;
        logic [31:0] res;
        int          lat;
        int          acc;
    } exp_t;
    exp_t sb[$];

    alu_mdu_seq #(.XLEN(32), .MDU_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .src1(src1), .src2(src2), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h want 0x%08h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] modelResult(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb2, sp;
        logic [63:0]        ua, ub, up;
        int                 ia, ib;
        sa = {{32{a[31]}}, a};
        sb2 = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        ia = a;
        ib = b;
        case (o)
            5'h00, 5'h02: return a + b;
            5'h01: return b;
            5'h03: return (a + b) & 32'hFFFF_FFFE;
            5'h04: return {31'b0, ia < ib};
            5'h05: return a ^ b;
            5'h06: return a | b;
            5'h07: return a & b;
            5'h08: return a << b[4:0];
            5'h09: return ia >>> b[4:0];
            5'h0A: return a >> b[4:0];
            5'h0B: return a - b;
            5'h0C: return {31'b0, a < b};
            5'h10: begin up = ua * ub; return up[31:0]; end
            5'h11: begin sp = sa * sb2; return sp[63:32]; end
            5'h12: begin sp = sa * $signed(ub); return sp[63:32]; end
            5'h13: begin up = ua * ub; return up[63:32]; end
            5'h14: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            5'h15: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'h16: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            5'h17: return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int modelLat(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o < 5'h10 || o > 5'h17) return 1;
        if (o >= 5'h14 && b == 0) return 1;
        if ((o == 5'h14 || o == 5'h16) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic pushExp(input string tag, input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.tag = tag;
        e.res = modelResult(o, a, b);
        e.lat = modelLat(o, a, b);
        e.acc = cyc;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input string tag, input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        op = o;
        src1 = a;
        src2 = b;
        #1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checkOutput({tag, "_accept_timeout"}, 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        pushExp(tag, o, a, b);
        in_valid = 1'b0;
    endtask

    task automatic collectResult();
        int   n, busyCnt;
        exp_t e;
        n = 0;
        busyCnt = 0;
        @(negedge clk);
        while (!out_valid && n < 200) begin
            if (busy) busyCnt++;
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            checkOutput("out_timeout", 32'd0, 32'd1);
            return;
        end
        if (sb.size() == 0) begin
            checkOutput("sb_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        lastExp = e.res;
        checkOutput(e.tag, result, e.res);
        checkOutput({e.tag, "_lat"}, 32'(cyc - e.acc + 1), 32'(e.lat));
        checkOutput({e.tag, "_busy"}, 32'(busyCnt), (e.lat > 1) ? 32'd32 : 32'd0);
    endtask

    task automatic runOne(input string tag, input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        applyStimulus(tag, o, a, b);
        collectResult();
    endtask

    initial begin
        logic [4:0] legal [0:20];
        exp_t       e;
        int         cnt;
        legal = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09, 5'h0A,
                  5'h0B, 5'h0C, 5'h10, 5'h11, 5'h12, 5'h13, 5'h14, 5'h15, 5'h16, 5'h17};
        clk = 0; rst = 1; flush = 0; in_valid = 0; out_ready = 1;
        op = 0; src1 = 0; src2 = 0; cyc = 0; total = 0; bad = 0; lastExp = 0;
        #12;
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("rst_result", result, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst = 0;

        runOne("sub", 5'h0B, 32'd5, 32'd7);
        runOne("slt", 5'h04, 32'hFFFF_FFFF, 32'd1);
        runOne("sltu", 5'h0C, 32'hFFFF_FFFF, 32'd1);
        runOne("sra", 5'h09, 32'h8000_0000, 32'h24);
        runOne("add", 5'h00, 32'd100, 32'hFFFF_FFF6);
        runOne("lui", 5'h01, 32'hDEAD_BEEF, 32'h1234_5000);
        runOne("jalr", 5'h03, 32'd5, 32'd4);
        runOne("sll", 5'h08, 32'h0000_0003, 32'h21);
        runOne("srl", 5'h0A, 32'h8000_0000, 32'd31);
        runOne("xor", 5'h05, 32'hF0F0_1234, 32'h0FF0_FFFF);
        runOne("badop", 5'h1F, 32'd9, 32'd9);

        runOne("mulh", 5'h11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        runOne("mulhu", 5'h13, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        runOne("mul", 5'h10, 32'd7, 32'hFFFF_FFFD);
        runOne("mulhsu", 5'h12, 32'hFFFF_FFFF, 32'd2);
        runOne("div", 5'h14, 32'hFFFF_FFF9, 32'd2);
        runOne("rem", 5'h16, 32'hFFFF_FFF9, 32'd2);
        runOne("div0", 5'h14, 32'd1234, 32'd0);
        runOne("remu0", 5'h17, 32'd1234, 32'd0);
        runOne("divovf", 5'h14, 32'h8000_0000, 32'hFFFF_FFFF);
        runOne("removf", 5'h16, 32'h8000_0000, 32'hFFFF_FFFF);
        runOne("divu", 5'h15, 32'hFFFF_FFFF, 32'd10);

        // Reset in the middle of a multiply discards it entirely
        applyStimulus("mul_rst", 5'h10, 32'd12345, 32'd678);
        repeat (5) @(negedge clk);
        rst = 1;
        #1;
        checkOutput("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("midrst_result", result, 32'd0);
        checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst = 0;
        sb.delete();
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        checkOutput("midrst_late", 32'(cnt), 32'd0);

        // Backpressure holds the result, then a back-to-back issue on the pop cycle
        out_ready = 0;
        applyStimulus("add_hold", 5'h00, 32'd3, 32'd4);
        repeat (5) begin
            @(negedge clk);
            checkOutput("hold_valid", {31'b0, out_valid}, 32'd1);
            checkOutput("hold_result", result, 32'd7);
            checkOutput("hold_in_ready", {31'b0, in_ready}, 32'd0);
        end
        e = sb.pop_front();
        checkOutput(e.tag, result, e.res);
        out_ready = 1;
        in_valid = 1;
        op = 5'h00;
        src1 = 32'd10;
        src2 = 32'd20;
        #1;
        checkOutput("b2b_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        pushExp("b2b_add", 5'h00, 32'd10, 32'd20);
        in_valid = 0;
        collectResult();

        // Flush during a divide cancels it and leaves the old result in place
        applyStimulus("divu_flush", 5'h15, 32'd1000, 32'd7);
        repeat (9) @(negedge clk);
        flush = 1;
        @(posedge clk);
        #1;
        flush = 0;
        checkOutput("flush_busy", {31'b0, busy}, 32'd0);
        checkOutput("flush_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("flush_result", result, lastExp);
        sb.delete();
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        checkOutput("flush_late", 32'(cnt), 32'd0);
        runOne("post_flush", 5'h15, 32'd1000, 32'd7);

        for (int i = 0; i < 16; i++) begin
            logic [31:0] a, b;
            logic [4:0]  o;
            o = legal[$urandom_range(0, 20)];
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            runOne($sformatf("rand%0d_op%02h", i, o), o, a, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
